monitor_sensores: RTL

MONITOR_SENSORES -- requirements
Module: monitor_sensores

---
 rtl/monitor_sensores_pkg.sv | 15 +
 rtl/monitor_sensores_if.sv | 13 +
 rtl/monitor_sensores_filtro_debounce.sv | 47 ++++
 rtl/monitor_sensores.sv | 110 +++++++++++
 4 files changed

// File: rtl/monitor_sensores_pkg.sv
// Shared definitions for the sensor monitor: state encodings and default timing parameters.
package monitor_sensores_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    PEDIDO = 2'b01,
    ESPERA = 2'b10,
    FALHA  = 2'b11
  } estado_t;

  localparam int DEBOUNCE_CYC_DEF = 4;
  localparam int EMPTY_CYC_DEF    = 8;
  localparam int COOLDOWN_CYC_DEF = 6;

endpackage

// File: rtl/monitor_sensores_if.sv
// Request/level/command bundle between the sensor monitor and its environment.
interface monitor_sensores_if;

  logic       BT;
  logic       SN;
  logic       MC;
  logic       BZ;
  logic [1:0] estado;

  modport master (output BT, output SN, input MC, input BZ, input estado);
  modport slave  (input BT, input SN, output MC, output BZ, output estado);

endinterface

// File: rtl/monitor_sensores_filtro_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce filter for the request button.
module filtro_debounce
  import monitor_sensores_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          out_r;
  logic [CW-1:0] cnt_r;

  // Synchronize the raw input, then commit a change only after it persists long enough
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      out_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= in;
      sync2_r <= sync1_r;
      if (sync2_r != out_r) begin
        if (cnt_r == CNT_LAST) begin
          out_r <= sync2_r;
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign out = out_r;

endmodule

// File: rtl/monitor_sensores.sv
// Dispense-request monitor: debounced button drives a request/cooldown FSM, with a sticky
// reservoir-empty alarm that overrides everything until reset.
module monitor_sensores
  import monitor_sensores_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int EMPTY_CYC    = EMPTY_CYC_DEF,
  parameter int COOLDOWN_CYC = COOLDOWN_CYC_DEF
) (
  input logic               clk,
  input logic               reset,
  monitor_sensores_if.slave bus
);

  localparam int EW = $clog2(EMPTY_CYC + 1);
  localparam int KW = $clog2(COOLDOWN_CYC + 1);
  localparam logic [EW-1:0] EMPTY_MAX = EW'(EMPTY_CYC);
  localparam logic [EW-1:0] EMPTY_ONE = EW'(1);
  localparam logic [KW-1:0] COOL_LOAD = KW'(COOLDOWN_CYC - 1);
  localparam logic [KW-1:0] COOL_ONE  = KW'(1);

  logic          bt_db_s;
  logic          bt_db_prev_r;
  logic          rise_s;
  logic          alarm_s;
  logic [EW-1:0] empty_cnt_r;
  logic [KW-1:0] cool_cnt_r;
  logic [KW-1:0] cool_cnt_nxt_s;
  estado_t       estado_r;
  estado_t       estado_nxt_s;
  logic          mc_r;
  logic          bz_r;

  filtro_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filtro (
    .clk   (clk),
    .reset (reset),
    .in    (bus.BT),
    .out   (bt_db_s)
  );

  assign rise_s  = bt_db_s & ~bt_db_prev_r;
  assign alarm_s = (empty_cnt_r == EMPTY_MAX);

  // Next-state and cooldown logic; the alarm overrides every state, including a rising edge
  always_comb begin
    estado_nxt_s   = estado_r;
    cool_cnt_nxt_s = cool_cnt_r;
    if (alarm_s) begin
      estado_nxt_s = FALHA;
    end else begin
      case (estado_r)
        OCIOSO: begin
          if (rise_s) begin
            estado_nxt_s = PEDIDO;
          end else begin
            estado_nxt_s = OCIOSO;
          end
        end
        PEDIDO: begin
          estado_nxt_s   = ESPERA;
          cool_cnt_nxt_s = COOL_LOAD;
        end
        ESPERA: begin
          // Edges seen here are intentionally discarded; only OCIOSO reacts to rise_s
          if (cool_cnt_r == '0) begin
            estado_nxt_s = OCIOSO;
          end else begin
            cool_cnt_nxt_s = cool_cnt_r - COOL_ONE;
          end
        end
        FALHA: begin
          estado_nxt_s = FALHA;
        end
        default: begin
          estado_nxt_s = OCIOSO;
        end
      endcase
    end
  end

  // State, counters and registered outputs; MC/BZ are decoded from the next state so they align with estado
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_r     <= OCIOSO;
      cool_cnt_r   <= '0;
      empty_cnt_r  <= '0;
      bt_db_prev_r <= 1'b0;
      mc_r         <= 1'b0;
      bz_r         <= 1'b0;
    end else begin
      estado_r     <= estado_nxt_s;
      cool_cnt_r   <= cool_cnt_nxt_s;
      bt_db_prev_r <= bt_db_s;
      mc_r         <= (estado_nxt_s == PEDIDO);
      bz_r         <= (estado_nxt_s == FALHA);
      if (bus.SN) begin
        empty_cnt_r <= '0;
      end else if (!alarm_s) begin
        empty_cnt_r <= empty_cnt_r + EMPTY_ONE;
      end else begin
        empty_cnt_r <= empty_cnt_r;
      end
    end
  end

  assign bus.MC     = mc_r;
  assign bus.BZ     = bz_r;
  assign bus.estado = estado_r;

endmodule
